piece_scheduler: RTL and testbench

PIECE_SCHEDULER -- requirements
Module: piece_scheduler

---
 rtl/piece_scheduler_if.sv | 36 +++
 rtl/piece_scheduler.sv | 172 +++++++++++++++++
 tb/tb_piece_scheduler.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/piece_scheduler_if.sv
// Bus bundle between piece_scheduler and its consumer.
// The preview signals exist only when PIECE_SCHEDULER_PREVIEW_EN is defined.
interface piece_scheduler_if;
   logic        start;
   logic        seed_load;
   logic [15:0] seed;
   logic        piece_take;
   logic [2:0]  piece;
   logic        piece_valid;
`ifdef PIECE_SCHEDULER_PREVIEW_EN
   logic [2:0]  preview;
   logic        preview_valid;
`endif
   logic [2:0]  bag_count;
   logic        busy;

`ifdef PIECE_SCHEDULER_PREVIEW_EN
   modport master (
      output start, seed_load, seed, piece_take,
      input  piece, piece_valid, preview, preview_valid, bag_count, busy
   );
   modport slave (
      input  start, seed_load, seed, piece_take,
      output piece, piece_valid, preview, preview_valid, bag_count, busy
   );
`else
   modport master (
      output start, seed_load, seed, piece_take,
      input  piece, piece_valid, bag_count, busy
   );
   modport slave (
      input  start, seed_load, seed, piece_take,
      output piece, piece_valid, bag_count, busy
   );
`endif
endinterface

// File: rtl/piece_scheduler.sv
// 7-bag random piece scheduler: Galois LFSR draws, bag flags, bounded retries.
// Define PIECE_SCHEDULER_PREVIEW_EN for a two-entry queue with a preview slot.
module piece_scheduler (
   input  logic              clk,
   input  logic              reset,
   piece_scheduler_if.slave  bus
);

   localparam logic [15:0] LfsrInit = 16'hACE1;
   localparam logic [15:0] LfsrTaps = 16'hB400;

   typedef enum logic [1:0] {StIdle, StDraw, StFull} state_e;

   state_e      state_q, state_d;
   logic [15:0] lfsr_q, lfsr_d;
   logic [6:0]  flags_q, flags_d;
   logic [2:0]  bag_count_q, bag_count_d;
   logic [2:0]  rej_q, rej_d;
   logic [2:0]  head_q, head_d;
   logic        head_vld_q, head_vld_d;
`ifdef PIECE_SCHEDULER_PREVIEW_EN
   logic [2:0]  tail_q, tail_d;
   logic        tail_vld_q, tail_vld_d;
`endif

   logic [2:0]  cand;
   logic [2:0]  lowest_clear;
   logic [2:0]  pick_id;
   logic [7:0]  used_mask;
   logic        drawing;
   logic        accept;
   logic        take;
   logic        full;

   assign cand      = lfsr_q[2:0];
   // ID 7 is never a legal piece, so it is permanently marked as used.
   assign used_mask = {1'b1, flags_q};
   assign drawing   = (state_q == StDraw);
   assign take      = bus.piece_take & head_vld_q;

   always_comb begin
      lowest_clear = 3'd0;
      for (int i = 6; i >= 0; i--) begin
         if (!flags_q[i]) lowest_clear = 3'(i);
      end
   end

   // Seven straight rejections force the lowest free ID on the eighth try.
   always_comb begin
      accept  = 1'b0;
      pick_id = cand;
      if (drawing) begin
         if (rej_q == 3'd7) begin
            accept  = 1'b1;
            pick_id = lowest_clear;
         end else if (!used_mask[cand]) begin
            accept = 1'b1;
         end
      end
   end

   always_comb begin
      lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LfsrTaps) : (lfsr_q >> 1);
      if (bus.seed_load) lfsr_d = (bus.seed == 16'h0000) ? LfsrInit : bus.seed;

      flags_d     = flags_q;
      bag_count_d = bag_count_q;
      rej_d       = rej_q;
      if (drawing) begin
         if (accept) begin
            rej_d = 3'd0;
            if (bag_count_q == 3'd6) begin
               flags_d     = 7'd0;
               bag_count_d = 3'd0;
            end else begin
               flags_d     = flags_q | (7'd1 << pick_id);
               bag_count_d = bag_count_q + 3'd1;
            end
         end else begin
            rej_d = rej_q + 3'd1;
         end
      end
   end

`ifdef PIECE_SCHEDULER_PREVIEW_EN
   always_comb begin
      head_d     = head_q;
      head_vld_d = head_vld_q;
      tail_d     = tail_q;
      tail_vld_d = tail_vld_q;
      if (take) begin
         head_d     = tail_q;
         head_vld_d = tail_vld_q;
         tail_d     = 3'd0;
         tail_vld_d = 1'b0;
      end
      // A new ID lands in whichever slot is first free after the shift.
      if (accept) begin
         if (!head_vld_d) begin
            head_d     = pick_id;
            head_vld_d = 1'b1;
         end else begin
            tail_d     = pick_id;
            tail_vld_d = 1'b1;
         end
      end
      full = tail_vld_d;
   end
`else
   always_comb begin
      head_d     = head_q;
      head_vld_d = head_vld_q;
      if (take) begin
         head_d     = 3'd0;
         head_vld_d = 1'b0;
      end
      if (accept) begin
         head_d     = pick_id;
         head_vld_d = 1'b1;
      end
      full = head_vld_d;
   end
`endif

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (bus.start) state_d = StDraw;
         StDraw:  if (full) state_d = StFull;
         StFull:  if (take) state_d = StDraw;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         lfsr_q      <= LfsrInit;
         flags_q     <= 7'd0;
         bag_count_q <= 3'd0;
         rej_q       <= 3'd0;
         head_q      <= 3'd0;
         head_vld_q  <= 1'b0;
`ifdef PIECE_SCHEDULER_PREVIEW_EN
         tail_q      <= 3'd0;
         tail_vld_q  <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         lfsr_q      <= lfsr_d;
         flags_q     <= flags_d;
         bag_count_q <= bag_count_d;
         rej_q       <= rej_d;
         head_q      <= head_d;
         head_vld_q  <= head_vld_d;
`ifdef PIECE_SCHEDULER_PREVIEW_EN
         tail_q      <= tail_d;
         tail_vld_q  <= tail_vld_d;
`endif
      end
   end

   assign bus.piece       = head_q;
   assign bus.piece_valid = head_vld_q;
   assign bus.bag_count   = bag_count_q;
   assign bus.busy        = (state_q == StDraw);
`ifdef PIECE_SCHEDULER_PREVIEW_EN
   assign bus.preview       = tail_q;
   assign bus.preview_valid = tail_vld_q;
`endif

endmodule

// File: tb/tb_piece_scheduler.sv
// Self-checking bench for piece_scheduler: reference model with scoreboard,
// table-driven draw runs and directed reset/hold sequences.
module tb_piece_scheduler;

`ifdef PIECE_SCHEDULER_PREVIEW_EN
   localparam int Depth = 2;
`else
   localparam int Depth = 1;
`endif

   typedef struct {
      bit          do_seed;
      logic [15:0] seed;
      int          n_take;
      int          take_delay;
      bit          cmp_ref;
      int          exp_bag;
   } run_t;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   piece_scheduler_if bus ();

   piece_scheduler dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model, written straight from the behavioural description.
   logic [15:0] m_lfsr;
   int          m_st;
   logic [7:0]  m_flags;
   int          m_cnt;
   int          m_rej;
   int          m_q[$];
   int          exp_q[$];

   always @(posedge clk) begin
      int id;
      bit acc;
      bit taken;
      if (reset) begin
         m_lfsr  = 16'hACE1;
         m_st    = 0;
         m_flags = '0;
         m_cnt   = 0;
         m_rej   = 0;
         m_q.delete();
         exp_q.delete();
      end else begin
         taken = bus.piece_take && (m_q.size() > 0);
         acc   = 1'b0;
         id    = 0;
         if (m_st == 1) begin
            if (m_rej == 7) begin
               acc = 1'b1;
               for (int i = 6; i >= 0; i--) if (!m_flags[i]) id = i;
            end else if (m_lfsr[2:0] != 3'd7 && !m_flags[m_lfsr[2:0]]) begin
               acc = 1'b1;
               id  = int'(m_lfsr[2:0]);
            end else begin
               m_rej++;
            end
         end
         if (acc) begin
            m_rej = 0;
            if (m_cnt == 6) begin
               m_flags = '0;
               m_cnt   = 0;
            end else begin
               m_flags[id] = 1'b1;
               m_cnt++;
            end
         end
         if (taken) void'(m_q.pop_front());
         if (acc) begin
            m_q.push_back(id);
            exp_q.push_back(id);
         end
         case (m_st)
            0:       if (bus.start) m_st = 1;
            1:       if (m_q.size() == Depth) m_st = 2;
            default: if (taken) m_st = 1;
         endcase
         if (bus.seed_load) m_lfsr = (bus.seed == 16'h0000) ? 16'hACE1 : bus.seed;
         else m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
      end
   end

   // Accept monitor: DRAW-to-accept gap and bag_count stepping.
   int         gap = 0;
   logic       prev_busy = 1'b0;
   logic [2:0] prev_cnt = 3'd0;

   always @(posedge clk) begin
      #1;
      if (reset) begin
         gap = 0;
      end else begin
         if (prev_busy) gap++;
         if (bus.bag_count != prev_cnt) begin
            chk("draw_gap_le8", int'(gap <= 8 && gap >= 1), 1);
            if (prev_cnt == 3'd6) chk("bag_wrap", bus.bag_count, 0);
            else chk("bag_inc", bus.bag_count, prev_cnt + 1);
            gap = 0;
         end else if (gap == 9) begin
            chk("draw_gap_le8", gap, 8);
         end
      end
      prev_busy = bus.busy;
      prev_cnt  = bus.bag_count;
   end

   task automatic cmp_state();
      chk("piece_valid", bus.piece_valid, int'(m_q.size() > 0));
      chk("bag_count", bus.bag_count, m_cnt);
      chk("busy", bus.busy, int'(m_st == 1));
      if (m_q.size() > 0) chk("piece", bus.piece, m_q[0]);
`ifdef PIECE_SCHEDULER_PREVIEW_EN
      chk("preview_valid", bus.preview_valid, int'(m_q.size() > 1));
      if (m_q.size() > 1) chk("preview", bus.preview, m_q[1]);
`endif
   endtask

   task automatic cyc();
      @(negedge clk);
      cmp_state();
   endtask

   task automatic idle_inputs();
      bus.start      = 1'b0;
      bus.seed_load  = 1'b0;
      bus.seed       = 16'h0000;
      bus.piece_take = 1'b0;
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      idle_inputs();
      repeat (n) cyc();
   endtask

   task automatic wait_valid();
      for (int i = 0; i < 40 && !bus.piece_valid; i++) cyc();
      if (!bus.piece_valid) chk("wait_valid", bus.piece_valid, 1);
   endtask

   task automatic take_one(output int id);
      id = int'(bus.piece);
      if (exp_q.size() == 0) chk("sb_nonempty", exp_q.size(), 1);
      else chk("sb_piece", id, exp_q.pop_front());
      bus.piece_take = 1'b1;
      cyc();
      bus.piece_take = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      run_t runs[6];
      int   seq[70];
      int   ref_seq[7];
      int   id;
      int   mask;
      int   head0;

      runs[0] = '{1'b0, 16'h0000, 7,  0, 1'b0, (7 + Depth) % 7};
      runs[1] = '{1'b1, 16'h0000, 7,  0, 1'b1, (7 + Depth) % 7};
      runs[2] = '{1'b0, 16'h0000, 70, 1, 1'b0, (70 + Depth) % 7};
      runs[3] = '{1'b1, 16'h0001, 21, 0, 1'b0, (21 + Depth) % 7};
      runs[4] = '{1'b1, 16'hBEEF, 9,  3, 1'b0, (9 + Depth) % 7};
      runs[5] = '{1'b1, 16'h1234, 12, 2, 1'b0, (12 + Depth) % 7};

      reset = 1'b1;
      idle_inputs();

      // Reset held two cycles, then idle with stray takes and no start.
      do_reset(2);
      chk("rst_piece", bus.piece, 0);
      chk("rst_piece_valid", bus.piece_valid, 0);
      chk("rst_bag_count", bus.bag_count, 0);
      chk("rst_busy", bus.busy, 0);
`ifdef PIECE_SCHEDULER_PREVIEW_EN
      chk("rst_preview", bus.preview, 0);
      chk("rst_preview_valid", bus.preview_valid, 0);
`endif
      reset = 1'b0;
      bus.piece_take = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cyc();
         chk("idle_no_valid", bus.piece_valid, 0);
         chk("idle_not_busy", bus.busy, 0);
      end
      bus.piece_take = 1'b0;

      for (int r = 0; r < 6; r++) begin
         do_reset(2);
         reset = 1'b0;
         if (runs[r].do_seed) begin
            bus.seed_load = 1'b1;
            bus.seed      = runs[r].seed;
            cyc();
            bus.seed_load = 1'b0;
         end
         bus.start = 1'b1;
         cyc();
         bus.start = 1'b0;
         mask = 0;
         for (int k = 0; k < runs[r].n_take; k++) begin
            wait_valid();
            repeat (runs[r].take_delay) cyc();
            take_one(id);
            seq[k] = id;
            mask   = mask | (1 << id);
            if (k % 7 == 6) begin
               chk("bag_perm", mask, 7'h7f);
               mask = 0;
            end
         end
         repeat (20) cyc();
         chk("final_bag_count", bus.bag_count, runs[r].exp_bag);
         chk("final_full", int'(bus.piece_valid & ~bus.busy), 1);
         if (r == 0) for (int i = 0; i < 7; i++) ref_seq[i] = seq[i];
         if (runs[r].cmp_ref) begin
            for (int i = 0; i < 7; i++) chk("seed0_vs_reset", seq[i], ref_seq[i]);
         end
      end

      // Never take: queue stays full and stable; start is ignored outside IDLE.
      do_reset(2);
      reset = 1'b0;
      bus.start = 1'b1;
      cyc();
      bus.start = 1'b0;
      for (int i = 0; i < 40 && m_st != 2; i++) cyc();
      head0 = (m_q.size() > 0) ? m_q[0] : -1;
      for (int i = 0; i < 20; i++) begin
         bus.start = (i == 5);
         cyc();
         chk("hold_piece", bus.piece, head0);
         chk("hold_valid", bus.piece_valid, 1);
         chk("hold_busy", bus.busy, 0);
`ifdef PIECE_SCHEDULER_PREVIEW_EN
         chk("hold_preview_valid", bus.preview_valid, 1);
`endif
      end
      bus.start = 1'b0;

      // Reset mid-bag with other controls asserted; restart begins a fresh bag.
      do_reset(2);
      reset = 1'b0;
      bus.start = 1'b1;
      cyc();
      bus.start = 1'b0;
      for (int i = 0; i < 200 && !(bus.bag_count == 3'd4 && bus.piece_valid); i++) begin
         if (bus.piece_valid) take_one(id);
         else cyc();
      end
      chk("pre_reset_bag4", int'(bus.bag_count == 3'd4 && bus.piece_valid), 1);
      reset          = 1'b1;
      bus.start      = 1'b1;
      bus.seed_load  = 1'b1;
      bus.seed       = 16'h1234;
      bus.piece_take = 1'b1;
      cyc();
      chk("mid_rst_piece", bus.piece, 0);
      chk("mid_rst_valid", bus.piece_valid, 0);
      chk("mid_rst_bag_count", bus.bag_count, 0);
      chk("mid_rst_busy", bus.busy, 0);
`ifdef PIECE_SCHEDULER_PREVIEW_EN
      chk("mid_rst_preview_valid", bus.preview_valid, 0);
`endif
      idle_inputs();
      reset     = 1'b0;
      bus.start = 1'b1;
      cyc();
      bus.start = 1'b0;
      chk("restart_busy", bus.busy, 1);
      chk("restart_bag_count", bus.bag_count, 0);
      wait_valid();
      chk("restart_first_bag_count", bus.bag_count, 1);
      chk("restart_first_piece", bus.piece, ref_seq[0]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
